// File: rtl/ring_freq_counter.sv
// ---------------------------------------------------------------------------
// ring_freq_counter
// Measurement end of the ring-oscillator interface. Enables the oscillator,
// synchronises F_ring into clk, and counts its rising edges over a gate window
// of g clk cycles to produce a frequency word (edges per window) for the ADPLL.
// Supports single-shot and continuous measurement.
//
// Ports
//   clk        reference clock, all logic on rising edge
//   rst_n      asynchronous active-low reset
//   F_ring     oscillator output, asynchronous to clk (must run below clk/2)
//   start      measurement request, sampled only in IDLE
//   cont       continuous mode, sampled in DONE
//   gate_len   window length in clk cycles (0 treated as 1), latched on accept
//   osc_en     ring oscillator enable
//   busy       high in every state except IDLE
//   freq_word  last completed edge count, holds until the next DONE
//   valid      one-cycle pulse in DONE
//   overflow   edge count of the current freq_word saturated
//
// State      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | oscillator off, waiting for start
// ST_ENABLE  | oscillator on, SETTLE cycles of start-up, edges ignored
// ST_MEASURE | counting synchronised rising edges for exactly g cycles
// ST_DONE    | publish result, then re-arm (cont) or return to IDLE
// ---------------------------------------------------------------------------
module ring_freq_counter #(
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 8,
   parameter int SETTLE      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              F_ring,
   input  logic              start,
   input  logic              cont,
   input  logic [GATE_W-1:0] gate_len,
   output logic              osc_en,
   output logic              busy,
   output logic [CNT_W-1:0]  freq_word,
   output logic              valid,
   output logic              overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENABLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int              SET_W     = $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [GATE_W-1:0]      r_gate;
   logic [GATE_W-1:0]      r_gate_cnt;
   logic [SET_W-1:0]       r_settle;
   logic [CNT_W-1:0]       r_count;
   logic                   r_ovf_int;
   logic                   r_osc_en;
   logic                   r_busy;
   logic                   r_valid;
   logic [CNT_W-1:0]       r_freq;
   logic                   r_overflow;

   logic                   w_edge;
   logic                   w_cnt_max;
   logic [CNT_W-1:0]       w_count_nxt;
   logic                   w_ovf_nxt;
   logic [GATE_W-1:0]      w_gate_ld;

   // Edge detection runs continuously; only MEASURE consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], F_ring};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_gate_ld   = (gate_len == '0) ? GATE_W'(1) : gate_len;
   assign w_cnt_max   = (r_count == '1);
   // Saturating count; an increment attempt at full scale flags overflow.
   assign w_count_nxt = (w_edge && !w_cnt_max) ? r_count + CNT_W'(1) : r_count;
   assign w_ovf_nxt   = r_ovf_int | (w_edge & w_cnt_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_gate     <= '0;
         r_gate_cnt <= '0;
         r_settle   <= '0;
         r_count    <= '0;
         r_ovf_int  <= 1'b0;
         r_osc_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_freq     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_ENABLE;
                  r_gate   <= w_gate_ld;
                  r_settle <= SETTLE_LD;
                  r_osc_en <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            ST_ENABLE: begin
               if (r_settle == SET_W'(1)) begin
                  r_state    <= ST_MEASURE;
                  r_gate_cnt <= r_gate;
                  r_count    <= '0;
                  r_ovf_int  <= 1'b0;
               end else begin
                  r_settle <= r_settle - SET_W'(1);
               end
            end
            ST_MEASURE: begin
               r_count   <= w_count_nxt;
               r_ovf_int <= w_ovf_nxt;
               // The final window cycle's edge is folded into the published result
               // so freq_word and valid appear together in DONE.
               if (r_gate_cnt == GATE_W'(1)) begin
                  r_state    <= ST_DONE;
                  r_valid    <= 1'b1;
                  r_freq     <= w_count_nxt;
                  r_overflow <= w_ovf_nxt;
               end else begin
                  r_gate_cnt <= r_gate_cnt - GATE_W'(1);
               end
            end
            ST_DONE: begin
               if (cont) begin
                  // Back-to-back windows: oscillator already running, no settle.
                  r_state    <= ST_MEASURE;
                  r_gate     <= w_gate_ld;
                  r_gate_cnt <= w_gate_ld;
                  r_count    <= '0;
                  r_ovf_int  <= 1'b0;
               end else begin
                  r_state  <= ST_IDLE;
                  r_osc_en <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_osc_en <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign osc_en    = r_osc_en;
   assign busy      = r_busy;
   assign valid     = r_valid;
   assign freq_word = r_freq;
   assign overflow  = r_overflow;

endmodule

// File: doc/ring_freq_counter.md
Name: ring_freq_counter

Overview:
- Measurement end of the ring-oscillator interface: drives the oscillator enable, samples the free-running F_ring output in the reference clock domain and counts its rising edges over a programmable gate window.
- Produces a digital frequency word, edges per gate window, for the ADPLL loop filter / phase accumulator.
- Supports single-shot and continuous measurement.

Parameters:
- CNT_W, 16, width of freq_word and the internal edge counter.
- GATE_W, 8, width of gate_len.
- SETTLE, 4, clk cycles osc_en is held high before counting starts (oscillator start-up), min 1.
- SYNC_STAGES, 2, synchronizer flops on F_ring, min 2.

Ports:
- clk  input  1  reference clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- F_ring  input  1  oscillator output, asynchronous to clk. Must run below clk/2 for correct counts.
- start  input  1  request a measurement; sampled only in IDLE.
- cont  input  1  continuous mode; sampled in DONE.
- gate_len  input  GATE_W  window length in clk cycles; latched on accept.
- osc_en  output  1  enable to the ring oscillator En pin.
- busy  output  1  high in every state except IDLE.
- freq_word  output  CNT_W  last completed count; holds until the next DONE.
- valid  output  1  one-cycle pulse in DONE.
- overflow  output  1  count for the current freq_word saturated.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; osc_en=0, busy=0, valid=0, overflow=0, freq_word=0; synchronizer, edge flop, counters = 0.
- Synchronizer: SYNC_STAGES flops, then one edge flop (prev).
  - edge = sync_out & ~prev; runs in every state.
  - Latency from F_ring rising to edge = SYNC_STAGES+1 cycles.
- Gate latch: accepted gate_len value g. g==0 is treated as 1.
- IDLE:
  - osc_en=0.
  - start=1 at edge k: latch g, clear settle counter, go ENABLE (busy=1 from k+1).
  - start=0: stay in IDLE.
- ENABLE:
  - osc_en=1.
  - Hold SETTLE cycles, then go MEASURE.
  - Edges are not counted.
  - Edge counter and overflow flag cleared on entry to MEASURE.
- MEASURE:
  - osc_en=1.
  - Exactly g cycles.
  - In each of those cycles edge=1 increments the edge counter.
  - Saturates at 2^CNT_W-1; the first increment attempt at that value sets overflow_int.
  - After the g-th cycle go DONE.
- DONE (1 cycle):
  - freq_word<=count, overflow<=overflow_int, valid=1.
  - cont=1: re-latch gate_len into g, clear counter, go MEASURE directly. osc_en stays 1, no re-settle.
  - cont=0: go IDLE; osc_en drops next cycle.
- Timing, single shot: start accepted at edge k -> valid high in cycle k+1+SETTLE+g.
- Timing, continuous: consecutive valid pulses are g+1 cycles apart.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - gate_len changes mid-window: no effect until the next latch.
  - cont deasserted mid-window: current window completes, then IDLE.
  - F_ring stuck low/high: count=0, valid still pulses, overflow=0.
  - An edge in the same cycle as the MEASURE->DONE transition: not counted. One window is exactly the g MEASURE cycles.
  - rst_n low mid-operation: immediate IDLE, osc_en=0, partial count discarded, freq_word cleared to 0.
- Outputs are registered (valid, freq_word, overflow, osc_en, busy from state flops); no combinational input-to-output paths.

Test Plan:
- F_ring period 10 clk cycles (5 high/5 low), SETTLE=4, start pulse at edge k, gate_len=100:
  - expect busy from k+1, osc_en high k+1..k+105;
  - valid only at cycle k+105;
  - freq_word=10 (±1 allowed only for phase; bench aligns phase to give exactly 10), overflow=0.
- Saturation (CNT_W=4 override): F_ring period 2 cycles, gate_len=40 -> freq_word=15, overflow=1. Next window with gate_len=10 -> freq_word=5, overflow=0.
- gate_len=0, F_ring period 2 cycles -> window of 1 cycle, freq_word ≤1, valid at k+1+SETTLE+1. Second start during busy -> no extra valid.
- Continuous: cont=1, gate_len=20, F_ring period 4:
  - valid pulses 21 cycles apart, each freq_word=5, osc_en never drops;
  - cont=0 mid-window -> one more valid, then IDLE and osc_en=0.
- rst_n asserted 7 cycles into MEASURE:
  - osc_en, busy, valid, freq_word drop to 0 asynchronously (same timestep);
  - after release, no valid until a new start.
- F_ring held 0 throughout a gate_len=50 run -> freq_word=0, overflow=0, valid pulse present.
